instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Writer-side counterpart of the control decoder in the single-cycle MIPS32 core.
- Accepts instruction fields over a valid/ready stream and encodes each one into a 32-bit MIPS word. The opcode and funct values are exactly those the decoder consumes.
- Writes each encoded word sequentially into instruction memory.
- Holds the CPU in reset until the program is fully loaded.

Parameters:
- ADDR_W, 6, word-address width of instruction memory. DEPTH = 2**ADDR_W words.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 resets).
- start  in  1  one-cycle pulse; begins a load session.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  bundle accepted on a cycle with in_valid & in_ready.
- in_class  in  3  instruction class: 0 R-type, 1 lw, 2 sw, 3 beq, 4 addi, 5 j, 6 jal, 7 invalid.
- in_rs  in  5  rs field.
- in_rt  in  5  rt field.
- in_rd  in  5  rd field.
- in_shamt  in  5  shamt field.
- in_funct  in  6  funct field, R-type only.
- in_imm  in  16  immediate/offset, I-type only.
- in_target  in  26  jump target, J-type only.
- in_last  in  1  marks the final instruction of the program.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded instruction.
- count  out  ADDR_W+1  number of words written this session.
- done  out  1  high in DONE state.
- err  out  1  sticky; set by any invalid class accepted this session.
- cpu_hold  out  1  CPU reset request; high in IDLE and LOAD.

Behaviour:
- **Reset (reset==0 at a clock edge):**
  - State goes to IDLE; count=0.
  - imem_we=0, imem_addr=0, imem_wdata=0.
  - in_ready=0, done=0, err=0, cpu_hold=1.
  - Reset mid-LOAD aborts the session; no write occurs on the cycle after the reset edge.
- **States:** IDLE, LOAD, DONE.
  - IDLE: in_ready=0. start -> LOAD.
  - LOAD: in_ready=1 when count<DEPTH. start is ignored.
  - DONE: in_ready=0, done=1, cpu_hold=0. start -> LOAD (restarts the session).
- **Entering LOAD:** count=0 and err=0 on the same edge.
- **Encoding** (combinational from the inputs, registered on accept):
  - R-type: {6'b000000, rs, rt, rd, shamt, funct}.
  - lw: {6'b100011, rs, rt, imm}.
  - sw: {6'b101011, rs, rt, imm}.
  - beq: {6'b000100, rs, rt, imm}.
  - addi: {6'b001000, rs, rt, imm}.
  - j: {6'b000010, target}.
  - jal: {6'b000011, target}.
  - Unused fields are ignored.
- **Write latency:** an accept at edge N produces imem_we=1 for exactly one cycle after N, with:
  - imem_addr = count value before the increment;
  - imem_wdata = the encoded word;
  - count incremented at edge N.
  - At most one write per cycle.
  - Back-to-back accepts give a continuous write stream.
- **Invalid class (7) accepted:**
  - err set (sticky); no write; count unchanged; state stays LOAD.
  - If in_last is also set, the FSM still goes to DONE.
- **Last / full:**
  - Accept with in_last=1 -> DONE on the same edge. The final write still issues in the following cycle, so imem_we may be high in the first DONE cycle.
  - Accepting the word that makes count==DEPTH forces DONE whether or not in_last is set.
  - in_ready is never high while count==DEPTH.
- **cpu_hold:** deasserts in the first DONE cycle and reasserts immediately on start.
- **Simultaneous start and in_valid in IDLE:** only start takes effect; in_ready is 0 that cycle.

Test Plan:
- Reset low 2 cycles -> cpu_hold=1 and all other outputs 0. Then start, then accept addi rs=0 rt=8 imm=5 -> next cycle imem_we=1, addr=0, wdata=0x20080005, count=1.
- Back-to-back stream, no bubbles, in_last on the last item:
  - lw rs=8 rt=9 imm=4;
  - R-type rs=8 rt=9 rd=10 funct=0x20;
  - beq rs=8 rt=9 imm=0xFFFF;
  - j target=0x10;
  - jal target=0x10.
  - Required writes at addr 0..4: 0x8D090004, 0x01095020, 0x1109FFFF, 0x08000010, 0x0C000010. done=1, cpu_hold=0, count=5.
- Invalid class 7 between two valid items -> err=1, only 2 writes at addr 0,1. A new start clears err.
- ADDR_W=2: feed 5 items with in_last=0 -> 4 writes at addr 0..3; DONE after the 4th accept; in_ready=0 for the 5th; count=4.
- Reset asserted the cycle after an accept -> no imem_we the next cycle, state IDLE, count=0, cpu_hold=1.
- start pulsed during LOAD -> ignored, count continues. start in DONE -> LOAD, count=0, cpu_hold=1 the next cycle.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - encodes MIPS32 instruction fields and loads them into instruction memory
module instr_encoder_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err,
  output logic              cpu_hold
);

  // Session states
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Instruction classes as presented on in_class
  localparam logic [2:0] C_RTYPE = 3'd0;
  localparam logic [2:0] C_LW    = 3'd1;
  localparam logic [2:0] C_SW    = 3'd2;
  localparam logic [2:0] C_BEQ   = 3'd3;
  localparam logic [2:0] C_ADDI  = 3'd4;
  localparam logic [2:0] C_J     = 3'd5;
  localparam logic [2:0] C_JAL   = 3'd6;

  // Opcodes matching the core's control decoder
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // Memory is full once count reaches DEPTH (only the MSB of count is set)
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic [31:0]       enc_word;
  logic              enc_ok;
  logic              accept;
  logic [ADDR_W:0]   count_inc;

  // Field-to-word encoder; class 7 yields no word and flags enc_ok low
  always_comb begin
    enc_word = 32'h0;
    enc_ok   = 1'b1;
    case (in_class)
      C_RTYPE: enc_word = {OP_RTYPE, in_rs, in_rt, in_rd, in_shamt, in_funct};
      C_LW:    enc_word = {OP_LW,    in_rs, in_rt, in_imm};
      C_SW:    enc_word = {OP_SW,    in_rs, in_rt, in_imm};
      C_BEQ:   enc_word = {OP_BEQ,   in_rs, in_rt, in_imm};
      C_ADDI:  enc_word = {OP_ADDI,  in_rs, in_rt, in_imm};
      C_J:     enc_word = {OP_J,     in_target};
      C_JAL:   enc_word = {OP_JAL,   in_target};
      default: enc_ok   = 1'b0;
    endcase
  end

  // Ready only while loading and memory has room; a full memory never accepts
  assign in_ready  = (state_q == S_LOAD) && !count_q[ADDR_W];
  assign accept    = in_valid && in_ready;
  assign count_inc = count_q + ONE;

  // Next-state logic for the session FSM and the registered write port
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (enc_ok) begin
            we_d    = 1'b1;
            addr_d  = count_q[ADDR_W-1:0];
            wdata_d = enc_word;
            count_d = count_inc;
            if (count_inc == DEPTH) state_d = S_DONE;
          end else begin
            err_d = 1'b1;
          end
          // An invalid last item still ends the session
          if (in_last) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any session and cancels a pending write
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign err        = err_q;
  assign done       = (state_q == S_DONE);
  assign cpu_hold   = (state_q != S_DONE);

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - directed self-checking bench for instr_encoder_loader
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [2:0]  in_class;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        in_last;

  logic        in_ready, imem_we, done, err, cpu_hold;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [6:0]  count;

  logic        s_in_ready, s_imem_we, s_done, s_err, s_cpu_hold;
  logic [1:0]  s_imem_addr;
  logic [31:0] s_imem_wdata;
  logic [2:0]  s_count;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .count(count),
    .done(done), .err(err), .cpu_hold(cpu_hold)
  );

  instr_encoder_loader #(.ADDR_W(2)) dut_small (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_class(in_class), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
    .imem_we(s_imem_we), .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata), .count(s_count),
    .done(s_done), .err(s_err), .cpu_hold(s_cpu_hold)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_item(input logic [2:0] c, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                          input logic [15:0] imm, input logic [25:0] tg, input logic last);
    in_class = c; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
    in_funct = fn; in_imm = imm; in_target = tg; in_last = last;
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; in_valid = 1'b0;
    step(); step();
    reset = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; in_valid = 1'b0;
    set_item(3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);
    step(); step();
    n_cmp++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL rst_cpu_hold got %b want 1", cpu_hold); end
    n_cmp++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL rst_we got %b want 0", imem_we); end
    n_cmp++; if (imem_addr !== 6'd0) begin n_fail++; $display("FAIL rst_addr got %h want 0", imem_addr); end
    n_cmp++; if (imem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata got %h want 0", imem_wdata); end
    n_cmp++; if (count !== 7'd0) begin n_fail++; $display("FAIL rst_count got %0d want 0", count); end
    n_cmp++; if ({in_ready, done, err} !== 3'b000) begin n_fail++; $display("FAIL rst_rdy_done_err got %b want 000", {in_ready, done, err}); end
    reset = 1'b1;
    // start and in_valid together in IDLE: only start acts
    set_item(3'd4, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd5, 26'd0, 1'b0);
    start = 1'b1; in_valid = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL idle_ready got %b want 0", in_ready); end
    step();
    start = 1'b0; in_valid = 1'b0;
    n_cmp++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL idle_start_we got %b want 0", imem_we); end
    n_cmp++; if (count !== 7'd0) begin n_fail++; $display("FAIL idle_start_count got %0d want 0", count); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready got %b want 1", in_ready); end
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_cmp++; if (imem_we !== 1'b1) begin n_fail++; $display("FAIL addi_we got %b want 1", imem_we); end
    n_cmp++; if (imem_addr !== 6'd0) begin n_fail++; $display("FAIL addi_addr got %h want 0", imem_addr); end
    n_cmp++; if (imem_wdata !== 32'h20080005) begin n_fail++; $display("FAIL addi_wdata got %h want 20080005", imem_wdata); end
    n_cmp++; if (count !== 7'd1) begin n_fail++; $display("FAIL addi_count got %0d want 1", count); end
    step();
    n_cmp++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL addi_we_pulse got %b want 0", imem_we); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_wd [5];
    exp_wd[0] = 32'h8D090004; exp_wd[1] = 32'h01095020; exp_wd[2] = 32'h1109FFFF;
    exp_wd[3] = 32'h08000010; exp_wd[4] = 32'h0C000010;
    do_reset();
    pulse_start();
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: set_item(3'd1, 5'd8, 5'd9, 5'd0, 5'd0, 6'h00, 16'h0004, 26'h0, 1'b0);
        1: set_item(3'd0, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'h0000, 26'h0, 1'b0);
        2: set_item(3'd3, 5'd8, 5'd9, 5'd0, 5'd0, 6'h00, 16'hFFFF, 26'h0, 1'b0);
        3: set_item(3'd5, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h10, 1'b0);
        default: set_item(3'd6, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h10, 1'b1);
      endcase
      step();
      n_cmp++; if (imem_we !== 1'b1 || imem_addr !== 6'(i) || imem_wdata !== exp_wd[i])
        begin n_fail++; $display("FAIL b2b_write%0d got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h", i, imem_we, imem_addr, imem_wdata, i, exp_wd[i]); end
    end
    in_valid = 1'b0; in_last = 1'b0;
    n_cmp++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin n_fail++; $display("FAIL b2b_done got done=%b hold=%b want done=1 hold=0", done, cpu_hold); end
    n_cmp++; if (count !== 7'd5) begin n_fail++; $display("FAIL b2b_count got %0d want 5", count); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_done got %b want 0", in_ready); end
    step();
    n_cmp++; if (imem_we !== 1'b0) begin n_fail++; $display("FAIL b2b_we_after got %b want 0", imem_we); end
  endtask

  task automatic test_invalid();
    do_reset();
    pulse_start();
    in_valid = 1'b1;
    set_item(3'd4, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd5, 26'd0, 1'b0);
    step();
    set_item(3'd7, 5'd1, 5'd2, 5'd3, 5'd4, 6'd5, 16'h1234, 26'h3FF, 1'b0);
    step();
    n_cmp++; if (imem_we !== 1'b0 || err !== 1'b1) begin n_fail++; $display("FAIL inv_nowrite got we=%b err=%b want we=0 err=1", imem_we, err); end
    n_cmp++; if (count !== 7'd1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL inv_count got cnt=%0d rdy=%b want cnt=1 rdy=1", count, in_ready); end
    set_item(3'd1, 5'd8, 5'd9, 5'd0, 5'd0, 6'd0, 16'h0004, 26'd0, 1'b1);
    step();
    in_valid = 1'b0; in_last = 1'b0;
    n_cmp++; if (imem_we !== 1'b1 || imem_addr !== 6'd1 || imem_wdata !== 32'h8D090004)
      begin n_fail++; $display("FAIL inv_second got we=%b addr=%0d data=%h want we=1 addr=1 data=8d090004", imem_we, imem_addr, imem_wdata); end
    n_cmp++; if (err !== 1'b1 || done !== 1'b1 || count !== 7'd2) begin n_fail++; $display("FAIL inv_done got err=%b done=%b cnt=%0d want 1 1 2", err, done, count); end
    pulse_start();
    n_cmp++; if (err !== 1'b0 || count !== 7'd0 || cpu_hold !== 1'b1 || done !== 1'b0)
      begin n_fail++; $display("FAIL inv_restart got err=%b cnt=%0d hold=%b done=%b want 0 0 1 0", err, count, cpu_hold, done); end
  endtask

  task automatic test_full();
    do_reset();
    pulse_start();
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_item(3'd4, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'(k), 26'd0, 1'b0);
      step();
      n_cmp++; if (s_imem_we !== 1'b1 || s_imem_addr !== 2'(k) || s_imem_wdata !== (32'h20080000 + 32'(k)))
        begin n_fail++; $display("FAIL full_write%0d got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h", k, s_imem_we, s_imem_addr, s_imem_wdata, k, 32'h20080000 + 32'(k)); end
    end
    n_cmp++; if (s_done !== 1'b1 || s_count !== 3'd4) begin n_fail++; $display("FAIL full_done got done=%b cnt=%0d want 1 4", s_done, s_count); end
    set_item(3'd4, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd4, 26'd0, 1'b0);
    n_cmp++; if (s_in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b want 0", s_in_ready); end
    step();
    in_valid = 1'b0;
    n_cmp++; if (s_imem_we !== 1'b0 || s_count !== 3'd4) begin n_fail++; $display("FAIL full_fifth got we=%b cnt=%0d want 0 4", s_imem_we, s_count); end
  endtask

  task automatic test_reset_abort();
    do_reset();
    pulse_start();
    in_valid = 1'b1;
    set_item(3'd4, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd5, 26'd0, 1'b0);
    step();
    reset = 1'b0;
    step();
    n_cmp++; if (imem_we !== 1'b0 || count !== 7'd0) begin n_fail++; $display("FAIL abort_write got we=%b cnt=%0d want 0 0", imem_we, count); end
    n_cmp++; if (cpu_hold !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL abort_idle got hold=%b rdy=%b want 1 0", cpu_hold, in_ready); end
    reset = 1'b1;
    step();
    n_cmp++; if (imem_we !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL abort_stay_idle got we=%b rdy=%b want 0 0", imem_we, in_ready); end
    in_valid = 1'b0;
  endtask

  task automatic test_start_in_load();
    do_reset();
    pulse_start();
    in_valid = 1'b1;
    set_item(3'd4, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd5, 26'd0, 1'b0);
    step(); step();
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++; if (count !== 7'd3 || imem_addr !== 6'd2 || imem_we !== 1'b1)
      begin n_fail++; $display("FAIL start_ignored got cnt=%0d addr=%0d we=%b want 3 2 1", count, imem_addr, imem_we); end
    in_last = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    n_cmp++; if (done !== 1'b1 || cpu_hold !== 1'b0 || count !== 7'd4) begin n_fail++; $display("FAIL start_done got done=%b hold=%b cnt=%0d want 1 0 4", done, cpu_hold, count); end
    pulse_start();
    n_cmp++; if (count !== 7'd0 || cpu_hold !== 1'b1 || in_ready !== 1'b1)
      begin n_fail++; $display("FAIL done_restart got cnt=%0d hold=%b rdy=%b want 0 1 1", count, cpu_hold, in_ready); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_invalid();
    test_full();
    test_reset_abort();
    test_start_in_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
